// File: rtl/vme_a24_d32_responder_if.sv
// VME A24/D32 responder port bundle: backplane control lines and the local register port.
// Signal names are given from the responder's point of view.
interface vme_a24_d32_responder_if;
    logic        VME_AS_n_i;
    logic        VME_WRITE_n_i;
    logic [5:0]  VME_AM_i;
    logic [1:0]  VME_DS_n_i;
    logic [5:0]  VME_GA_i;
    logic        VME_DTACK_n_o;
    logic        VME_DTACK_OE_o;
    logic        VME_BERR_o;
    logic        VME_DATA_DIR_o;
    logic        VME_DATA_OE_N_o;
    logic        VME_ADDR_DIR_o;
    logic        VME_ADDR_OE_N_o;
    logic [21:0] loc_adr_o;
    logic [31:0] loc_dat_o;
    logic        loc_we_o;
    logic        loc_stb_o;
    logic [31:0] loc_dat_i;
    logic        loc_ack_i;

    modport slave (
        input  VME_AS_n_i, VME_WRITE_n_i, VME_AM_i, VME_DS_n_i, VME_GA_i,
        output VME_DTACK_n_o, VME_DTACK_OE_o, VME_BERR_o, VME_DATA_DIR_o,
        output VME_DATA_OE_N_o, VME_ADDR_DIR_o, VME_ADDR_OE_N_o,
        output loc_adr_o, loc_dat_o, loc_we_o, loc_stb_o,
        input  loc_dat_i, loc_ack_i
    );

    modport master (
        output VME_AS_n_i, VME_WRITE_n_i, VME_AM_i, VME_DS_n_i, VME_GA_i,
        input  VME_DTACK_n_o, VME_DTACK_OE_o, VME_BERR_o, VME_DATA_DIR_o,
        input  VME_DATA_OE_N_o, VME_ADDR_DIR_o, VME_ADDR_OE_N_o,
        input  loc_adr_o, loc_dat_o, loc_we_o, loc_stb_o,
        output loc_dat_i, loc_ack_i
    );
endinterface

// File: rtl/vme_a24_d32_responder.sv
// Minimal VME64x A24/D32 single-cycle slave: geographic slot decode, transceiver control,
// DTACK/BERR generation and a strobe/ack local register port with timeout.
module vme_a24_d32_responder #(
    parameter int g_TIMEOUT = 255,
    parameter int g_SYNC    = 2
) (
    input  logic                      clk_sys_i,
    input  logic                      rst_n_i,
    vme_a24_d32_responder_if.slave    bus,
    inout  wire                       VME_LWORD_n_b,
    inout  wire  [31:1]               VME_ADDR_b,
    inout  wire  [31:0]               VME_DATA_b
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DSWAIT  = 3'd1;
    localparam logic [2:0] ST_LOCAL   = 3'd2;
    localparam logic [2:0] ST_ACK     = 3'd3;
    localparam logic [2:0] ST_ERR     = 3'd4;
    localparam logic [2:0] ST_RELEASE = 3'd5;
    localparam logic [2:0] ST_ASWAIT  = 3'd6;
    localparam logic [15:0] TMO_LAST  = 16'(g_TIMEOUT - 1);

    logic [g_SYNC-1:0][3:0] sync_q;
    logic       as_s;
    logic [1:0] ds_s;
    logic       write_s;

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[g_SYNC-2:0], {bus.VME_WRITE_n_i, bus.VME_DS_n_i, bus.VME_AS_n_i}};
        end
    end

    assign as_s    = sync_q[g_SYNC-1][0];
    assign ds_s    = sync_q[g_SYNC-1][2:1];
    assign write_s = sync_q[g_SYNC-1][3];

    // GA carries the inverted slot number plus an odd-parity bit; slot 0 means "no slot".
    logic [4:0] slot;
    logic       ga_ok;
    logic       match;
    logic       unused_addr;

    assign slot        = ~bus.VME_GA_i[4:0];
    assign ga_ok       = (bus.VME_GA_i[5] == ^slot) && (slot != 5'd0);
    assign match       = ga_ok && ((bus.VME_AM_i == 6'h39) || (bus.VME_AM_i == 6'h3D)) &&
                         (VME_ADDR_b[23:19] == slot);
    assign unused_addr = ^VME_ADDR_b[31:24];

    logic [2:0]  state_q,    state_d;
    logic [21:0] loc_adr_q,  loc_adr_d;
    logic [31:0] loc_dat_q,  loc_dat_d;
    logic        loc_we_q,   loc_we_d;
    logic        loc_stb_q,  loc_stb_d;
    logic [31:0] rd_data_q,  rd_data_d;
    logic        a1_q,       a1_d;
    logic        lword_q,    lword_d;
    logic        ds_part_q,  ds_part_d;
    logic [15:0] tmo_q,      tmo_d;
    logic        dtack_n_q,  dtack_n_d;
    logic        dtack_oe_q, dtack_oe_d;
    logic        berr_q,     berr_d;
    logic        data_dir_q, data_dir_d;
    logic        go_release;

    always_comb begin
        state_d    = state_q;
        loc_adr_d  = loc_adr_q;
        loc_dat_d  = loc_dat_q;
        loc_we_d   = loc_we_q;
        loc_stb_d  = loc_stb_q;
        rd_data_d  = rd_data_q;
        a1_d       = a1_q;
        lword_d    = lword_q;
        ds_part_d  = ds_part_q;
        tmo_d      = tmo_q;
        dtack_n_d  = dtack_n_q;
        dtack_oe_d = dtack_oe_q;
        berr_d     = berr_q;
        data_dir_d = data_dir_q;
        go_release = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!as_s) begin
                    if (match) begin
                        state_d   = ST_DSWAIT;
                        loc_adr_d = VME_ADDR_b[23:2];
                        a1_d      = VME_ADDR_b[1];
                        lword_d   = VME_LWORD_n_b;
                        ds_part_d = 1'b0;
                    end else begin
                        state_d = ST_ASWAIT;
                    end
                end
            end
            ST_DSWAIT: begin
                // A lone strobe seen on two consecutive cycles is a D16/D08 access, not skew.
                if (as_s) begin
                    go_release = 1'b1;
                end else if (ds_s == 2'b00) begin
                    if (!lword_q && !a1_q) begin
                        state_d   = ST_LOCAL;
                        loc_we_d  = ~write_s;
                        loc_dat_d = VME_DATA_b;
                        loc_stb_d = 1'b1;
                        tmo_d     = 16'd0;
                    end else begin
                        state_d = ST_ERR;
                        berr_d  = 1'b1;
                    end
                end else if (ds_s != 2'b11) begin
                    if (ds_part_q) begin
                        state_d = ST_ERR;
                        berr_d  = 1'b1;
                    end else begin
                        ds_part_d = 1'b1;
                    end
                end else begin
                    ds_part_d = 1'b0;
                end
            end
            ST_LOCAL: begin
                if (as_s) begin
                    go_release = 1'b1;
                end else if (bus.loc_ack_i) begin
                    state_d   = ST_ACK;
                    loc_stb_d = 1'b0;
                    rd_data_d = bus.loc_dat_i;
                    if (loc_we_q) begin
                        dtack_oe_d = 1'b1;
                        dtack_n_d  = 1'b0;
                    end else begin
                        data_dir_d = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = ST_ERR;
                    loc_stb_d = 1'b0;
                    berr_d    = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            ST_ACK: begin
                // Reads put data on the bus one cycle ahead of DTACK.
                if (as_s) begin
                    go_release = 1'b1;
                end else if (!dtack_oe_q) begin
                    dtack_oe_d = 1'b1;
                    dtack_n_d  = 1'b0;
                end else if (ds_s == 2'b11) begin
                    go_release = 1'b1;
                end
            end
            ST_ERR: begin
                if (as_s || (ds_s == 2'b11)) begin
                    go_release = 1'b1;
                end
            end
            ST_RELEASE: begin
                dtack_oe_d = 1'b0;
                state_d    = ST_ASWAIT;
            end
            ST_ASWAIT: begin
                if (as_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (go_release) begin
            state_d    = ST_RELEASE;
            loc_stb_d  = 1'b0;
            dtack_n_d  = 1'b1;
            berr_d     = 1'b0;
            data_dir_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            loc_adr_q  <= '0;
            loc_dat_q  <= '0;
            loc_we_q   <= 1'b0;
            loc_stb_q  <= 1'b0;
            rd_data_q  <= '0;
            a1_q       <= 1'b0;
            lword_q    <= 1'b1;
            ds_part_q  <= 1'b0;
            tmo_q      <= '0;
            dtack_n_q  <= 1'b1;
            dtack_oe_q <= 1'b0;
            berr_q     <= 1'b0;
            data_dir_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            loc_adr_q  <= loc_adr_d;
            loc_dat_q  <= loc_dat_d;
            loc_we_q   <= loc_we_d;
            loc_stb_q  <= loc_stb_d;
            rd_data_q  <= rd_data_d;
            a1_q       <= a1_d;
            lword_q    <= lword_d;
            ds_part_q  <= ds_part_d;
            tmo_q      <= tmo_d;
            dtack_n_q  <= dtack_n_d;
            dtack_oe_q <= dtack_oe_d;
            berr_q     <= berr_d;
            data_dir_q <= data_dir_d;
        end
    end

    assign VME_DATA_b          = data_dir_q ? rd_data_q : 32'bz;
    assign bus.VME_DTACK_n_o   = dtack_n_q;
    assign bus.VME_DTACK_OE_o  = dtack_oe_q;
    assign bus.VME_BERR_o      = berr_q;
    assign bus.VME_DATA_DIR_o  = data_dir_q;
    assign bus.VME_DATA_OE_N_o = 1'b0;
    assign bus.VME_ADDR_DIR_o  = 1'b0;
    assign bus.VME_ADDR_OE_N_o = 1'b0;
    assign bus.loc_adr_o       = loc_adr_q;
    assign bus.loc_dat_o       = loc_dat_q;
    assign bus.loc_we_o        = loc_we_q;
    assign bus.loc_stb_o       = loc_stb_q;
endmodule
